// File: rtl/multicycle_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS control FSM.
// State enum, opcode/funct constants, ALU control codes, and the pc_src /
// alu_src_b select codes used by the controller and its ALU decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath bundle.
// master = controller (reads op/funct/zero/mem_ready, drives all selects),
// slave  = datapath/memory side.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       ext_sel;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
           alu_src_b, alu_control, ext_sel, reg_dst, mem_to_reg, reg_write,
           illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a,
           alu_src_b, alu_control, ext_sel, reg_dst, mem_to_reg, reg_write,
           illegal
  );
endinterface

// File: rtl/multicycle_ctrl_aludec.sv
// mc_aludec: combinational R-type funct decoder.
// Ports: i_funct (IR[5:0]) -> o_alu_control (ALU op), o_bad_funct (funct
// not in the supported R-type set).
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_control,
  output logic       o_bad_funct
);
  always_comb begin
    o_alu_control = ALU_ADD;
    o_bad_funct   = 1'b0;
    case (i_funct)
      FN_ADD:  o_alu_control = ALU_ADD;
      FN_SUB:  o_alu_control = ALU_SUB;
      FN_AND:  o_alu_control = ALU_AND;
      FN_OR:   o_alu_control = ALU_OR;
      FN_SLT:  o_alu_control = ALU_SLT;
      default: o_bad_funct   = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-style control FSM for the multicycle MIPS datapath.
// Ports: clk, rst_n (async, active-low); bus (master modport) carrying
// op/funct/zero/mem_ready in and every datapath select/enable out.
// Outputs are decoded combinationally from r_state and the live inputs,
// and are forced to zero whenever rst_n is low.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);
  state_t     r_state, w_next;
  logic [2:0] w_fn_alu;
  logic       w_bad_funct;

  logic       w_mem_req, w_mem_write, w_iord, w_ir_write, w_pc_en;
  logic [1:0] w_pc_src, w_alu_src_b;
  logic       w_alu_src_a, w_ext_sel, w_reg_dst, w_mem_to_reg;
  logic       w_reg_write, w_illegal;
  logic [2:0] w_alu_control;

  mc_aludec u_aludec (
    .i_funct       (bus.funct),
    .o_alu_control (w_fn_alu),
    .o_bad_funct   (w_bad_funct)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_iord        = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_en       = 1'b0;
    w_pc_src      = PCSRC_ALU;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = SRCB_RT;
    w_alu_control = ALU_AND;
    w_ext_sel     = 1'b1;
    w_reg_dst     = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_reg_write   = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      FETCH: begin
        // PC+4 computed every fetch cycle; PC/IR only commit on mem_ready
        w_mem_req     = 1'b1;
        w_alu_src_b   = SRCB_FOUR;
        w_alu_control = ALU_ADD;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_en    = 1'b1;
          w_next     = DECODE;
        end
      end
      DECODE: begin
        // speculative branch target into ALUOut
        w_alu_src_b   = SRCB_IMMSH;
        w_alu_control = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW:               w_next = MEMADR;
          OP_BEQ:                     w_next = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   w_next = IMMEX;
          OP_J:                       w_next = JUMP;
          OP_RTYPE: begin
            w_next    = w_bad_funct ? FETCH : EXECUTE;
            w_illegal = w_bad_funct;
          end
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        w_alu_src_a   = 1'b1;
        w_alu_src_b   = SRCB_IMM;
        w_alu_control = ALU_ADD;
        w_next        = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        if (bus.mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_next       = FETCH;
      end
      MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready) w_next = FETCH;
      end
      EXECUTE: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = w_fn_alu;
        w_next        = ALUWB;
      end
      ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_next      = FETCH;
      end
      BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_SUB;
        w_pc_src      = PCSRC_ALUOUT;
        w_pc_en       = bus.zero;
        w_next        = FETCH;
      end
      IMMEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = IMMWB;
        case (bus.op)
          OP_ANDI: begin w_alu_control = ALU_AND; w_ext_sel = 1'b0; end
          OP_ORI:  begin w_alu_control = ALU_OR;  w_ext_sel = 1'b0; end
          default:       w_alu_control = ALU_ADD;
        endcase
      end
      IMMWB: begin
        w_reg_write = 1'b1;
        w_next      = FETCH;
      end
      JUMP: begin
        w_pc_src = PCSRC_JUMP;
        w_pc_en  = 1'b1;
        w_next   = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

  // reset squashes every output immediately, ext_sel included
  assign bus.mem_req     = rst_n & w_mem_req;
  assign bus.mem_write   = rst_n & w_mem_write;
  assign bus.iord        = rst_n & w_iord;
  assign bus.ir_write    = rst_n & w_ir_write;
  assign bus.pc_en       = rst_n & w_pc_en;
  assign bus.pc_src      = rst_n ? w_pc_src      : 2'b00;
  assign bus.alu_src_a   = rst_n & w_alu_src_a;
  assign bus.alu_src_b   = rst_n ? w_alu_src_b   : 2'b00;
  assign bus.alu_control = rst_n ? w_alu_control : 3'b000;
  assign bus.ext_sel     = rst_n & w_ext_sel;
  assign bus.reg_dst     = rst_n & w_reg_dst;
  assign bus.mem_to_reg  = rst_n & w_mem_to_reg;
  assign bus.reg_write   = rst_n & w_reg_write;
  assign bus.illegal     = rst_n & w_illegal;
endmodule
